clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl_if.sv | 21 ++
 rtl/clk_div_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake for clk_div_ctrl.
// The master offers a divide ratio; the slave accepts it when ready.
interface clk_div_ctrl_if #(
    parameter int W = 16
);
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty clock divider.
// Ratio changes take effect only at a falling edge of O_CLK.
module clk_div_ctrl #(
    parameter int W       = 16,
    parameter int DEF_DIV = 20
) (
    input  logic          I_CLK,
    input  logic          rst,
    input  logic          en,
    clk_div_ctrl_if.slave cfg,
    output logic          O_CLK,
    output logic          O_TICK,
    output logic          busy,
    output logic          err
);

    localparam int CW = W - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  active_q, active_d;
    logic [W-1:0]  pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          oclk_q, oclk_d;
    logic          tick_q, tick_d;
    logic          err_q, err_d;

    logic          wrap, hs, bad, leave;
    logic [CW-1:0] cnt_step;
    logic          oclk_step, tick_step;

    assign wrap = {1'b0, cnt_q} == (active_q >> 1) - W'(1);

    assign cfg.cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign hs  = cfg.cfg_valid & cfg.cfg_ready;
    assign bad = cfg.cfg_div[0] | (cfg.cfg_div < W'(2));

    assign cnt_step  = wrap ? '0 : cnt_q + CW'(1);
    assign oclk_step = oclk_q ^ wrap;
    assign tick_step = wrap & ~oclk_q;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        oclk_d   = oclk_q;
        tick_d   = 1'b0;
        err_d    = hs & bad;
        leave    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hs && !bad) active_d = cfg.cfg_div;
                if (en) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    oclk_d  = 1'b0;
                end
            end
            RUN: begin
                cnt_d  = cnt_step;
                oclk_d = oclk_step;
                tick_d = tick_step;
                if (hs && !bad) begin
                    pend_d  = cfg.cfg_div;
                    state_d = PEND;
                end
                if (!en) state_d = STOP;
            end
            PEND: begin
                cnt_d  = cnt_step;
                oclk_d = oclk_step;
                tick_d = tick_step;
                // swap ratio only on the 1->0 wrap so no half is cut short
                if (wrap && oclk_q) begin
                    active_d = pend_q;
                    pend_d   = '0;
                    state_d  = RUN;
                end
                if (!en) state_d = STOP;
            end
            STOP: begin
                if (oclk_q) begin
                    cnt_d  = cnt_step;
                    oclk_d = oclk_step;
                    tick_d = tick_step;
                    leave  = wrap;
                end else begin
                    cnt_d = '0;
                    leave = 1'b1;
                end
                if (leave) begin
                    state_d = IDLE;
                    if (pend_q != '0) begin
                        active_d = pend_q;
                        pend_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (!rst) begin
            state_q  <= IDLE;
            active_q <= W'(DEF_DIV);
            pend_q   <= '0;
            cnt_q    <= '0;
            oclk_q   <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            oclk_q   <= oclk_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign O_CLK  = oclk_q;
    assign O_TICK = tick_q;
    assign err    = err_q;
    assign busy   = state_q != IDLE;

endmodule
